// File: rtl/program_counter_pkg.sv
// Shared constants and next-state selection for the Hack-style program counter.
package program_counter_pkg;

  localparam int PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VALUE = '0;

  typedef enum logic [1:0] {
    PC_OP_HOLD  = 2'd0,
    PC_OP_INC   = 2'd1,
    PC_OP_LOAD  = 2'd2,
    PC_OP_RESET = 2'd3
  } pc_op_e;

  // Strict priority: reset > load > inc > hold.
  function automatic pc_op_e pc_select_op(input logic reset, input logic load,
                                          input logic inc);
    pc_op_e op;
    if (reset)     op = PC_OP_RESET;
    else if (load) op = PC_OP_LOAD;
    else if (inc)  op = PC_OP_INC;
    else           op = PC_OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/program_counter_inc16.sv
// WIDTH-bit combinational incrementer (out = in + 1, wrapping), shared with the gate library.
module inc16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = in + WIDTH'(1);

endmodule

// File: rtl/program_counter.sv
// Program counter: clear / load / increment / hold into one register, out driven from the flop.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE);

  // Declaration initialiser gives the defined zero value before any reset or edge.
  logic [WIDTH-1:0] pc_q = RESET_VALUE;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus_one;
  pc_op_e           pc_op;

  inc16 #(.WIDTH(WIDTH)) u_inc16 (
    .in  (pc_q),
    .out (pc_plus_one)
  );

  always_comb begin
    pc_op = pc_select_op(reset, load, inc);
    pc_d  = pc_q;
    case (pc_op)
      PC_OP_RESET: pc_d = RESET_VALUE;
      PC_OP_LOAD:  pc_d = in;
      PC_OP_INC:   pc_d = pc_plus_one;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VALUE;
    else       pc_q <= pc_d;
  end

  assign out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: priority, wrap-around and synchronous behaviour.
module tb_program_counter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic         inc = 1'b0;
  logic [W-1:0] in_v = '0;
  logic [W-1:0] out_v;

  int n_checks = 0;
  int n_fail   = 0;

  program_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_v),
    .load  (load),
    .inc   (inc),
    .out   (out_v)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] observed,
                          input logic [W-1:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Apply controls, take one rising edge, sample 1ns later.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic i, input logic [W-1:0] d,
                      input logic [W-1:0] expected);
    reset = r;
    load  = l;
    inc   = i;
    in_v  = d;
    @(posedge clk);
    #1;
    check_eq(tag, out_v, expected);
  endtask

  initial begin
    #1;
    check_eq("power_up", out_v, 16'h0000);

    step("hold_0",        0, 0, 0, 16'h0000, 16'h0000);
    step("hold_1",        0, 0, 0, 16'h0000, 16'h0000);

    step("inc_1",         0, 0, 1, 16'h0000, 16'h0001);
    step("inc_2",         0, 0, 1, 16'h0000, 16'h0002);
    step("load_neg",      0, 1, 1, 16'h8285, 16'h8285);
    step("inc_neg_1",     0, 0, 1, 16'h8285, 16'h8286);
    step("inc_neg_2",     0, 0, 1, 16'h8285, 16'h8287);

    step("load_12345",    0, 1, 0, 16'h3039, 16'h3039);
    step("rst_load",      1, 1, 0, 16'h3039, 16'h0000);
    step("load_inc",      0, 1, 1, 16'h3039, 16'h3039);
    step("rst_load_inc",  1, 1, 1, 16'h3039, 16'h0000);
    step("inc_after_rst", 0, 0, 1, 16'h3039, 16'h0001);
    step("rst_inc",       1, 0, 1, 16'h3039, 16'h0000);

    step("load_zero",     0, 1, 1, 16'h0000, 16'h0000);
    step("inc_from_zero", 0, 0, 1, 16'h0000, 16'h0001);
    step("rst_over_data", 1, 0, 0, 16'h56CE, 16'h0000);

    step("load_ffff",     0, 1, 0, 16'hFFFF, 16'hFFFF);
    step("wrap_ffff",     0, 0, 1, 16'hFFFF, 16'h0000);
    step("load_7fff",     0, 1, 0, 16'h7FFF, 16'h7FFF);
    step("wrap_7fff",     0, 0, 1, 16'h7FFF, 16'h8000);

    step("hold_8000",     0, 0, 0, 16'h0000, 16'h8000);
    #1;
    reset = 1'b1;
    load  = 1'b1;
    in_v  = 16'h1234;
    #1;
    check_eq("mid_cycle_pulse", out_v, 16'h8000);
    reset = 1'b0;
    load  = 1'b0;
    in_v  = 16'h0000;
    @(posedge clk);
    #1;
    check_eq("after_released_pulse", out_v, 16'h8000);

    reset = 1'b1;
    #2;
    check_eq("mid_cycle_reset", out_v, 16'h8000);
    @(posedge clk);
    #1;
    check_eq("reset_sampled", out_v, 16'h0000);

    reset = 1'b0;
    load  = 1'b1;
    in_v  = 16'hBEEF;
    #2;
    check_eq("mid_cycle_load", out_v, 16'h0000);
    @(posedge clk);
    #1;
    check_eq("load_sampled", out_v, 16'hBEEF);
    load = 1'b0;
    #3;
    check_eq("stable_between_edges", out_v, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

16-bit program counter for the Hack-style CPU datapath. Holds the address of the current instruction and, on each rising clock edge, does one of four things: clears to zero, loads a jump target, advances by one, or holds. Sits between the CPU control logic (jump/reset decisions) and instruction-memory addressing.

## Interface
- `WIDTH`, default 16: counter and data width in bits.
- `clk`, input, 1: single system clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high clear; highest priority.
- `in`, input, `WIDTH`: load value (jump target), two's-complement or unsigned bit pattern.
- `load`, input, 1: when high (and `reset` low), capture `in`.
- `inc`, input, 1: when high (and `reset`, `load` low), add 1.
- `out`, output, `WIDTH`: current register value, driven directly from the register.

## Operation
- Next-state selection at each rising `clk`, strict priority:
  - `reset`=1: next = 0, regardless of `load`, `inc`, `in`.
  - else `load`=1: next = `in`, regardless of `inc`.
  - else `inc`=1: next = `out` + 1.
  - else: next = `out` (hold).
- Arithmetic:
  - Increment is modulo 2^`WIDTH`; 0xFFFF + 1 = 0x0000 with no carry output.
  - Bit patterns are treated as signed values, so 0x7FFF + 1 = 0x8000 (−32768). Loading −32123 (0x8285) and incrementing gives −32122.
- Register initial value is 0 at power-up/time zero, so `out` = 0 before any reset or clock edge.
- No illegal input combinations. All 8 combinations of `reset`/`load`/`inc` are defined by the priority list above.

## Timing
- Latency is one cycle: inputs sampled at rising edge N appear on `out` immediately after edge N and stay stable until edge N+1.
- `out` has no combinational path from `in`, `reset`, `load` or `inc`. Input changes between edges never affect `out`.
- Reset is synchronous. Asserting `reset` between edges does nothing until the next rising edge, which then gives `out` = 0.
- Reset during an increment sequence discards the count. `inc` held with `reset` still gives 0 at that edge; counting resumes from 0 on the next edge after `reset` drops.
- Reset value of `out`: 0.

## Structure
- Shared package constants:
  - `PC_WIDTH` = 16.
  - `PC_RESET_VALUE` = 0.
- Sub-module `inc16`: `WIDTH`-bit combinational incrementer producing `out + 1` with wrap. It is shared with the ALU/gate library.
- Top level: priority mux chain (reset > load > inc > hold) feeding a single `WIDTH`-bit register with synchronous clear.

## Test plan
- Power-up and hold: all controls low for 2 edges → `out` = 0 throughout.
- Increment: `inc`=1 for 2 edges from 0 → `out` = 1, then 2. Load `in`=−32123 with `load`=`inc`=1 → −32123 (load beats inc). Then `inc` only for 2 edges → −32122, −32121.
- Load and reset priority:
  - `load`=1, `in`=12345 → 12345.
  - `reset`=`load`=1 → 0.
  - `load`=`inc`=1 → 12345.
  - `reset`=`load`=`inc`=1 → 0.
  - `inc` → 1.
  - `reset`=`inc`=1 → 0.
- Load zero and reset-over-data: `load`=`inc`=1, `in`=0 → 0. Then `inc` → 1. Then `reset`=1, `in`=22222 → 0.
- Wrap-around: load 0xFFFF, `inc` → 0x0000. Load 0x7FFF, `inc` → 0x8000.
- Synchronicity: toggle `reset`/`load`/`in` mid-cycle and release before the edge → `out` unchanged until an edge samples them.
